// File: rtl/hex_ui_pkg.sv
// rtl/hex_ui_pkg.sv - shared types and key indices for the hex entry controller
package hex_ui_pkg;

  typedef logic [3:0] nibble_t;

  // Bit positions within key_n
  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;
  localparam int KEY_SEL = 2;
  localparam int KEY_CLR = 3;

  typedef enum logic [1:0] {
    RPT_IDLE      = 2'd0,
    RPT_ARMED     = 2'd1,
    RPT_REPEATING = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, debouncer and auto-repeat event generator
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   key_n  raw active-low pushbutton
//   evt    registered one-cycle pulse per accepted press or auto-repeat
module key_debounce
  import hex_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic evt
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1, sync2;
  logic          d, d_dly;
  logic [DW-1:0] cnt;
  rpt_state_t    state;
  logic [RW-1:0] rcnt;
  logic          press, rpt;

  // Synchroniser stores the inverted (pressed) level; reset value = released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
    end
  end

  // cnt counts consecutive samples disagreeing with the accepted state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d     <= 1'b0;
      d_dly <= 1'b0;
      cnt   <= '0;
    end else begin
      d_dly <= d;
      if (sync2 == d) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        d   <= ~d;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = d & ~d_dly;

  // Gated by d so a release in the terminal-count cycle cannot fire a repeat.
  assign rpt = REPEAT_EN && d &&
               (((state == RPT_ARMED) && (rcnt == DELAY_LAST)) ||
                ((state == RPT_REPEATING) && (rcnt == PERIOD_LAST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RPT_IDLE;
      rcnt  <= '0;
    end else if (!d || !REPEAT_EN) begin
      state <= RPT_IDLE;
      rcnt  <= '0;
    end else begin
      case (state)
        RPT_IDLE: begin
          if (press) begin
            state <= RPT_ARMED;
            rcnt  <= '0;
          end
        end
        RPT_ARMED: begin
          if (rcnt == DELAY_LAST) begin
            state <= RPT_REPEATING;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RPT_REPEATING: begin
          if (rcnt == PERIOD_LAST) rcnt <= '0;
          else                     rcnt <= rcnt + 1'b1;
        end
        default: begin
          state <= RPT_IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end

  // Registering the event keeps key_n fully isolated from the top-level outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) evt <= 1'b0;
    else       evt <= press | rpt;
  end

endmodule

// File: rtl/hex_entry_ctrl.sv
// rtl/hex_entry_ctrl.sv - pushbutton-driven multi-digit hex value entry
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   key_n    raw active-low keys: [0] inc, [1] dec, [2] next digit, [3] clear
//   value    current hex value, 4*DIGITS bits
//   digits   value split into one nibble per display digit
//   sel      index of the digit inc/dec act on
//   changed  one-cycle pulse after each actual value change
module hex_entry_ctrl
  import hex_ui_pkg::*;
#(
  parameter int DIGITS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int VW             = 4 * DIGITS,
  localparam int SW             = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             key_n,
  output logic [VW-1:0]          value,
  output nibble_t [DIGITS-1:0]   digits,
  output logic [SW-1:0]          sel,
  output logic                   changed
);

  localparam logic [SW-1:0] SEL_LAST = SW'(DIGITS - 1);

  logic [3:0]    evt;
  logic [VW-1:0] step;
  logic          inc, dec, nxt, clr;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (k == KEY_INC || k == KEY_DEC)
    ) u_key (
      .clk   (clk),
      .reset (reset),
      .key_n (key_n[k]),
      .evt   (evt[k])
    );
  end

  assign inc = evt[KEY_INC];
  assign dec = evt[KEY_DEC];
  assign nxt = evt[KEY_SEL];
  assign clr = evt[KEY_CLR];

  // Adding at the selected nibble lets carries/borrows ripple naturally.
  assign step = VW'(1) << {sel, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value   <= '0;
      sel     <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (clr) begin
        value   <= '0;
        sel     <= '0;
        changed <= (value != '0);
      end else begin
        // Simultaneous inc and dec cancel; step is never zero so any
        // single inc/dec always changes the value.
        if (inc && !dec) begin
          value   <= value + step;
          changed <= 1'b1;
        end else if (dec && !inc) begin
          value   <= value - step;
          changed <= 1'b1;
        end
        if (nxt) sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      end
    end
  end

  assign digits = value;

endmodule

// File: doc/hex_entry_ctrl.md
Name: hex_entry_ctrl

Overview:
- Upstream of the per-digit hex-to-seven-segment decoders on the lab board.
- Turns the four raw active-low pushbuttons into a DIGITS-nibble hex value.
- Per-key processing: synchronise, debounce, edge-detect, auto-repeat.
- Supplies one 4-bit nibble per display digit plus the selected-digit index, so top level can feed each decoder and blank or flash the cursor.

Parameters:
- DIGITS, 3, number of hex digits held; value width is 4*DIGITS.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a key change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat (inc/dec only).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_n  input  4  raw pushbuttons, active low, asynchronous: [0] inc, [1] dec, [2] next digit, [3] clear
- value  output  4*DIGITS  current hex value
- digits  output  DIGITS x 4 (packed)  digits[i] = value[4i+3:4i], one per hex decoder
- sel  output  $clog2(DIGITS) (min 1)  index of digit that inc/dec act on
- changed  output  1  one-cycle pulse on the cycle after any value update

Behaviour:
- Reset (async assert, sync release):
  - value=0, sel=0, changed=0.
  - All debounced key states = released; all counters 0.
- Synchronisation: each key_n bit passes through a 2-flop synchroniser; s = synchronised "pressed" (inverted key_n).
- Debounce, per key, debounced state d and counter cnt:
  - cycle with s==d: cnt<=0.
  - s!=d and cnt==DEBOUNCE_CYCLES-1: d flips, cnt<=0.
  - otherwise: cnt increments.
  - A d 0->1 transition raises a one-cycle press event.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Latency: key_n held low from edge 0 → value updated at edge DEBOUNCE_CYCLES+3; changed high for the following cycle.
- Auto-repeat (keys 0,1 only), per-key FSM:
  - IDLE: d=0. Enter ARMED on press event, hold counter = 0.
  - ARMED: counter reaches REPEAT_DELAY-1 → repeat event, counter = 0, go to REPEATING.
  - REPEATING: counter reaches REPEAT_PERIOD-1 → repeat event, counter = 0.
  - Any state with d=0 → IDLE, counter = 0.
  - Keys 2,3: press event only, never repeat.
  - Holding a key never produces more than one event per cycle.
- Value update, one per cycle, priority order:
  1. clear event: value=0, sel=0; inc/dec/select ignored that cycle.
  2. inc and dec events in same cycle: cancel, value unchanged, changed not pulsed.
  3. inc: value += 1<<(4*sel), modulo 2^(4*DIGITS); carries propagate into higher digits; all-F + 1 wraps to 0.
  4. dec: value -= 1<<(4*sel), modulo 2^(4*DIGITS); borrows propagate; 0 - 1 at sel=0 wraps to all-F.
- Select:
  - select event: sel <= (sel==DIGITS-1) ? 0 : sel+1.
  - Same-cycle inc/dec uses the old sel.
- changed pulses only when value actually changes. Clear at value 0 gives no pulse.
- Reset mid-press: debounced state returns to released. A key still held after reset release must re-debounce and then produces exactly one press event.
- Outputs are registered; no combinational path from key_n to any output.

Decomposition:
- Package hex_ui_pkg:
  - nibble_t (logic [3:0]).
  - key index constants KEY_INC=0, KEY_DEC=1, KEY_SEL=2, KEY_CLR=3.
  - enum rpt_state_t {RPT_IDLE, RPT_ARMED, RPT_REPEATING}.
- Sub-module key_debounce, instantiated 4×:
  - Parameters: DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, REPEAT_EN.
  - Contents: synchroniser, debounce counter, repeat FSM.
  - Output: one-cycle event pulse.
- Top level: arbitration, value/sel registers, digit slicing.

Test Plan (DIGITS=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Reset, then key_n[0] low for 10 cycles and released → value 0x000→0x001 exactly at edge 7; changed pulses once; no repeat.
- key_n[0] low with 2-cycle glitches (low 2, high 2, repeated 10×) → value stays 0x000, changed never asserts.
- Press key 2 twice (sel=2), then hold key 1 for 40 cycles from value 0x000 → 0xF00 at press, then 0xE00 at +20, 0xD00 at +25, 0xC00 at +30 … (one step per 5 cycles); releasing stops repeats.
- Carry/wrap:
  - value 0x0FF, sel=0, inc → 0x100.
  - value 0xFFF, inc → 0x000.
  - value 0x000, sel=0, dec → 0xFFF.
- Simultaneous events:
  - keys 0 and 1 pressed on the same cycle → no value change, no changed pulse.
  - keys 0 and 3 pressed together at value 0x123 → value 0x000, sel 0.
- Hold key 0 and assert reset for 3 cycles mid-REPEATING → outputs 0 immediately on reset assertion; after release a fresh press event gives value 0x001 at DEBOUNCE_CYCLES+3 edges.
